// File: rtl/alu_op_issuer_pkg.sv
// Shared definitions for the ALU operation issuer.
//   - Opcode constants for the 8-bit Processador datapath (OP_NOP, OP_ADD .. OP_XNOR).
//   - Response error codes (ERR_OK, ERR_ILLEGAL, ERR_DIVZERO).
//   - Issuer FSM state encoding.
//   - screen_cmd(): classifies an incoming command before it is issued.
package alu_op_issuer_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_MUL  = 8'h03;
    localparam logic [7:0] OP_DIV  = 8'h04;
    localparam logic [7:0] OP_MOD  = 8'h05;
    localparam logic [7:0] OP_AND  = 8'h06;
    localparam logic [7:0] OP_OR   = 8'h07;
    localparam logic [7:0] OP_XOR  = 8'h08;
    localparam logic [7:0] OP_NOT  = 8'h09;
    localparam logic [7:0] OP_SHL  = 8'h0A;
    localparam logic [7:0] OP_SHR  = 8'h0B;
    localparam logic [7:0] OP_XNOR = 8'h0C;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_DIVZERO = 2'b10
    } err_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Illegal opcodes take priority over the divisor check, so an
    // out-of-range opcode with a zero operand2 reports ERR_ILLEGAL.
    function automatic err_t screen_cmd(input logic [7:0] opcode,
                                        input logic       divisor_is_zero);
        err_t result;
        result = ERR_OK;
        if ((opcode == OP_NOP) || (opcode > OP_XNOR)) begin
            result = ERR_ILLEGAL;
        end else if (((opcode == OP_DIV) || (opcode == OP_MOD)) && divisor_is_zero) begin
            result = ERR_DIVZERO;
        end
        return result;
    endfunction

endpackage

// File: rtl/alu_op_issuer_sat_counter.sv
// sat_counter: saturating event counter used for the optional issue statistics.
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset, clears the count
//   inc    in   count one event this cycle
//   count  out  W-bit count, sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: command-side initiator for the 8-bit Processador datapath.
// A host command {opcode, operand1, operand2} is accepted over valid/ready,
// screened, driven onto the processor inputs and held for the datapath
// latency; the registered result and flags are then returned with an error
// code over a second valid/ready channel.
//
// Handshake rule (both channels): a transfer happens on the rising edge where
// valid && ready are both high; the sender keeps its payload stable while
// valid is high and ready is low; only one command is ever outstanding.
//
// Ports
//   clk, reset                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command channel
//   cmd_opcode/operand1/operand2  command payload (legal opcodes 01..0C)
//   proc_opcode/operand1/operand2 drive to the processor
//   proc_result/proc_flags        registered result from the processor
//   rsp_valid/rsp_ready           response channel
//   rsp_result/flags/error        response payload (error 00 ok, 01 illegal, 10 div0)
//   busy                          FSM is not IDLE
//   stat_issued/stat_errors       statistics, only when ISSUE_STATS_EN is defined
//   dbg_state                     current FSM state, for observation
//
// Build option: define ISSUE_STATS_EN to add the two saturating statistics counters.
module alu_op_issuer
    import alu_op_issuer_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int PROC_LATENCY = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_opcode,
    input  logic [DATA_W-1:0] cmd_operand1,
    input  logic [DATA_W-1:0] cmd_operand2,
    output logic [7:0]        proc_opcode,
    output logic [DATA_W-1:0] proc_operand1,
    output logic [DATA_W-1:0] proc_operand2,
    input  logic [DATA_W-1:0] proc_result,
    input  logic [DATA_W-1:0] proc_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [DATA_W-1:0] rsp_flags,
    output logic [1:0]        rsp_error,
    output logic              busy,
`ifdef ISSUE_STATS_EN
    output logic [CNT_W-1:0]  stat_issued,
    output logic [CNT_W-1:0]  stat_errors,
`endif
    output state_t            dbg_state
);

    localparam int WAIT_W = (PROC_LATENCY > 0) ? $clog2(PROC_LATENCY + 1) : 1;

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              ready_en_q;
    err_t              pend_err_q;
    err_t              rsp_error_q;
    err_t              screen;
    logic              accept;
    logic              capture;
    logic              rsp_fire;

    // Keeps cmd_ready low while reset is held and for the release edge, so
    // every output reads 0 in reset and cmd_ready rises one cycle after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    assign screen   = screen_cmd(cmd_opcode, (cmd_operand2 == '0));
    assign accept   = cmd_valid && cmd_ready;
    assign capture  = (state_q == ST_WAIT) && (wait_cnt_q == '0);
    assign rsp_fire = rsp_valid && rsp_ready;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // A rejected command still passes through WAIT, with the counter loaded
    // to zero, so its response appears one edge after acceptance; a legal
    // command waits PROC_LATENCY+1 edges for the processor's registered result.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = ready_en_q;
                if (cmd_valid && ready_en_q) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = (screen == ERR_OK) ? WAIT_W'(PROC_LATENCY) : '0;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Processor drive and response capture
    // proc_* only change on a legal accept (and proc_opcode returns to NOP
    // at the response handshake), so they are constant throughout WAIT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            proc_opcode   <= OP_NOP;
            proc_operand1 <= '0;
            proc_operand2 <= '0;
            pend_err_q    <= ERR_OK;
            rsp_error_q   <= ERR_OK;
            rsp_result    <= '0;
            rsp_flags     <= '0;
        end else begin
            if (accept) begin
                pend_err_q <= screen;
                if (screen == ERR_OK) begin
                    proc_opcode   <= cmd_opcode;
                    proc_operand1 <= cmd_operand1;
                    proc_operand2 <= cmd_operand2;
                end else begin
                    rsp_result <= '0;
                    rsp_flags  <= '0;
                end
            end
            if (capture) begin
                rsp_error_q <= pend_err_q;
                if (pend_err_q == ERR_OK) begin
                    rsp_result <= proc_result;
                    rsp_flags  <= proc_flags;
                end
            end
            if (rsp_fire) begin
                proc_opcode <= OP_NOP;
            end
        end
    end

    assign rsp_error = rsp_error_q;
    assign dbg_state = state_q;

`ifdef ISSUE_STATS_EN
    // Both counters step at the accept edge, classified by the screen result.
    sat_counter #(.W(CNT_W)) u_stat_issued (
        .clk   (clk),
        .reset (reset),
        .inc   (accept && (screen == ERR_OK)),
        .count (stat_issued)
    );

    sat_counter #(.W(CNT_W)) u_stat_errors (
        .clk   (clk),
        .reset (reset),
        .inc   (accept && (screen != ERR_OK)),
        .count (stat_errors)
    );
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
`timescale 1ns/1ps
module tb_alu_op_issuer;
    import alu_op_issuer_pkg::*;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int LAT    = 2;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [7:0]        cmd_opcode;
    logic [DATA_W-1:0] cmd_operand1;
    logic [DATA_W-1:0] cmd_operand2;
    logic [7:0]        proc_opcode;
    logic [DATA_W-1:0] proc_operand1;
    logic [DATA_W-1:0] proc_operand2;
    logic [DATA_W-1:0] proc_result;
    logic [DATA_W-1:0] proc_flags;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic [DATA_W-1:0] rsp_flags;
    logic [1:0]        rsp_error;
    logic              busy;
    state_t            dbg_state;
`ifdef ISSUE_STATS_EN
    logic [CNT_W-1:0]  stat_issued;
    logic [CNT_W-1:0]  stat_errors;
`endif

    int checks = 0;
    int errors = 0;
    int exp_issued = 0;
    int exp_errors = 0;
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;
    logic [17:0] exp_q[$];

    alu_op_issuer #(.DATA_W(DATA_W), .PROC_LATENCY(LAT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_opcode    (cmd_opcode),
        .cmd_operand1  (cmd_operand1),
        .cmd_operand2  (cmd_operand2),
        .proc_opcode   (proc_opcode),
        .proc_operand1 (proc_operand1),
        .proc_operand2 (proc_operand2),
        .proc_result   (proc_result),
        .proc_flags    (proc_flags),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_flags     (rsp_flags),
        .rsp_error     (rsp_error),
        .busy          (busy),
`ifdef ISSUE_STATS_EN
        .stat_issued   (stat_issued),
        .stat_errors   (stat_errors),
`endif
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- ALU behaviour (processor stand-in and reference) ----------------
    function automatic logic [7:0] alu_res(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            8'h01: return a + b;
            8'h02: return a - b;
            8'h03: return a * b;
            8'h04: return (b == 8'h00) ? 8'hFF : a / b;
            8'h05: return (b == 8'h00) ? 8'hFF : a % b;
            8'h06: return a & b;
            8'h07: return a | b;
            8'h08: return a ^ b;
            8'h09: return ~a;
            8'h0A: return a << 1;
            8'h0B: return a >> 1;
            8'h0C: return ~(a ^ b);
            default: return 8'h00;
        endcase
    endfunction

    // flags[0] = zero, flags[1] = carry out of ADD
    function automatic logic [7:0] alu_flg(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (op == 8'h00 || op > 8'h0C) return 8'h00;
        return {6'b0, (op == 8'h01) ? s[8] : 1'b0, alu_res(op, a, b) == 8'h00};
    endfunction

    // Two-stage processor: operands into regA/B, then result into regC.
    logic [7:0] reg_op, reg_a, reg_b;
    always @(posedge clk) begin
        reg_op      <= proc_opcode;
        reg_a       <= proc_operand1;
        reg_b       <= proc_operand2;
        proc_result <= alu_res(reg_op, reg_a, reg_b);
        proc_flags  <= alu_flg(reg_op, reg_a, reg_b);
    end

    // Issuer reference: error classification from the opcode rules.
    function automatic logic [1:0] ref_err(input logic [7:0] op, input logic [7:0] b);
        if (op == 8'h00 || op > 8'h0C) return 2'b01;
        if ((op == 8'h04 || op == 8'h05) && b == 8'h00) return 2'b10;
        return 2'b00;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef ISSUE_STATS_EN
        check({tag, " stat_issued"}, 32'(stat_issued), exp_issued);
        check({tag, " stat_errors"}, 32'(stat_errors), exp_errors);
`endif
    endtask

    // ---------------- driver ----------------
    // Starts at a negedge, finishes at a negedge with the DUT back in IDLE.
    task automatic run_txn(input string tag, input logic [7:0] op, input logic [7:0] a,
                           input logic [7:0] b, input int hold, input logic [7:0] e_res,
                           input logic [7:0] e_flg, input logic [1:0] e_err, input int e_lat);
        int wait_n;
        int lat;
        logic [7:0] e_pop;
        logic [7:0] e_pa;
        logic [7:0] e_pb;
        e_pop = (e_err == 2'b00) ? op : 8'h00;
        e_pa  = (e_err == 2'b00) ? a : last_a;
        e_pb  = (e_err == 2'b00) ? b : last_b;
        cmd_opcode = op; cmd_operand1 = a; cmd_operand2 = b; cmd_valid = 1'b1;
        wait_n = 0;
        while (!cmd_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check({tag, " accept"}, 32'(cmd_ready), 1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_opcode = 8'($urandom); cmd_operand1 = 8'($urandom); cmd_operand2 = 8'($urandom);
        if (e_err == 2'b00) begin
            exp_issued++;
            last_a = a;
            last_b = b;
        end else begin
            exp_errors++;
        end
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            check({tag, " wait proc"}, {proc_opcode, proc_operand1, proc_operand2}, {e_pop, e_pa, e_pb});
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, e_lat);
        if (!rsp_valid) return;
        check({tag, " rsp payload"}, {rsp_result, rsp_flags, 6'b0, rsp_error}, {e_res, e_flg, 6'b0, e_err});
        check({tag, " resp ctl"}, {busy, cmd_ready}, 2'b10);
        check({tag, " proc hold"}, {proc_opcode, proc_operand1, proc_operand2}, {e_pop, e_pa, e_pb});
        check_stats(tag);
        for (int h = 0; h < hold; h++) begin
            // an intruding command that must be ignored while a response is pending
            cmd_valid = 1'b1; cmd_opcode = 8'h01;
            cmd_operand1 = 8'($urandom); cmd_operand2 = 8'($urandom);
            @(negedge clk);
            check({tag, " stall"}, {rsp_valid, cmd_ready, rsp_result, rsp_flags, rsp_error},
                  {1'b1, 1'b0, e_res, e_flg, e_err});
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " after rsp"}, {rsp_valid, cmd_ready, busy, proc_opcode}, {1'b0, 1'b1, 1'b0, 8'h00});
        check({tag, " operands kept"}, {proc_operand1, proc_operand2}, {last_a, last_b});
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         hold;
        logic [7:0] res;
        logic [7:0] flg;
        logic [1:0] err;
        int         lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{8'h01, 8'h05, 8'h03, 5, 8'h08, 8'h00, 2'b00, 3};
        vecs[1]  = '{8'h02, 8'h05, 8'h05, 0, 8'h00, 8'h01, 2'b00, 3};
        vecs[2]  = '{8'h04, 8'h09, 8'h00, 0, 8'h00, 8'h00, 2'b10, 1};
        vecs[3]  = '{8'h0D, 8'h12, 8'h34, 1, 8'h00, 8'h00, 2'b01, 1};
        vecs[4]  = '{8'h00, 8'h01, 8'h01, 0, 8'h00, 8'h00, 2'b01, 1};
        vecs[5]  = '{8'hFF, 8'hAA, 8'h00, 0, 8'h00, 8'h00, 2'b01, 1};
        vecs[6]  = '{8'h05, 8'h07, 8'h00, 2, 8'h00, 8'h00, 2'b10, 1};
        vecs[7]  = '{8'h03, 8'h04, 8'h05, 0, 8'h14, 8'h00, 2'b00, 3};
        vecs[8]  = '{8'h01, 8'hFF, 8'h01, 1, 8'h00, 8'h03, 2'b00, 3};
        vecs[9]  = '{8'h0C, 8'h0F, 8'hF0, 0, 8'h00, 8'h01, 2'b00, 3};
        vecs[10] = '{8'h04, 8'h09, 8'h02, 0, 8'h04, 8'h00, 2'b00, 3};
        vecs[11] = '{8'h05, 8'h11, 8'h04, 0, 8'h01, 8'h00, 2'b00, 3};
        vecs[12] = '{8'h0B, 8'h81, 8'h00, 0, 8'h40, 8'h00, 2'b00, 3};
        vecs[13] = '{8'h0A, 8'h81, 8'h07, 0, 8'h02, 8'h00, 2'b00, 3};

        cmd_valid = 1'b0; cmd_opcode = 8'h00; cmd_operand1 = 8'h00; cmd_operand2 = 8'h00;
        rsp_ready = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("reset ctl", {cmd_ready, rsp_valid, busy}, 3'b000);
        check("reset proc", {proc_opcode, proc_operand1, proc_operand2}, 24'h0);
        check("reset rsp", {rsp_result, rsp_flags, 6'b0, rsp_error}, 24'h0);
        check("reset state", 32'(dbg_state), 32'(ST_IDLE));
        check_stats("reset");

        reset = 1'b1;
        #1 check("release cmd_ready low", 32'(cmd_ready), 0);
        @(posedge clk);
        #1 check("release cmd_ready high", 32'(cmd_ready), 1);
        @(negedge clk);

        // table-driven directed vectors
        for (int i = 0; i < 14; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold,
                    vecs[i].res, vecs[i].flg, vecs[i].err, vecs[i].lat);
        end

        // reset asserted while a legal command is in WAIT
        cmd_opcode = 8'h01; cmd_operand1 = 8'h11; cmd_operand2 = 8'h22; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("midrst in wait", {busy, rsp_valid, proc_opcode}, {1'b1, 1'b0, 8'h01});
        reset = 1'b0;
        #1;
        check("midrst outputs", {busy, rsp_valid, cmd_ready, proc_opcode, proc_operand1, proc_operand2},
              {3'b000, 24'h0});
        exp_issued = 0; exp_errors = 0; last_a = 8'h00; last_b = 8'h00;
        check_stats("midrst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 check("midrst cmd_ready", 32'(cmd_ready), 1);
        repeat (4) @(negedge clk);
        check("midrst discarded", {rsp_valid, busy}, 2'b00);

        // randomized commands against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [7:0] op, a, b;
            logic [1:0] e;
            logic [17:0] ex;
            op = 8'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            e  = ref_err(op, b);
            if (e == 2'b00) exp_q.push_back({alu_res(op, a, b), alu_flg(op, a, b), e});
            else            exp_q.push_back({8'h00, 8'h00, e});
            ex = exp_q.pop_front();
            run_txn($sformatf("rnd%0d op%0h", n, op), op, a, b, int'($urandom_range(0, 3)),
                    ex[17:10], ex[9:2], ex[1:0], (e == 2'b00) ? LAT + 1 : 1);
        end
        check_stats("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
